// File: rtl/fp_inv_sqrt_arbiter.sv
// Round-robin front end that time-shares one non-pipelined fp_inv_sqrt_folded unit
// between NUM_REQ requesters, with a watchdog guarding each outstanding operation.
module fp_inv_sqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic [WIDTH-1:0]         resp_data_out,
    output logic                     resp_err_out,
    output logic [WIDTH-1:0]         unit_a_out,
    output logic                     unit_valid_out,
    input  logic                     unit_ready_in,
    input  logic [WIDTH-1:0]         unit_res_in,
    input  logic                     unit_valid_in
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;
    logic             grant_vld_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [WIDTH-1:0] grant_op_s;

    // Round-robin search: first valid requester at or above rr_ptr_q, wrapping.
    always_comb begin
        sum_s       = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        grant_op_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s       = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            cand_s      = (sum_s >= NREQ_EXT) ? IDX_W'(sum_s - NREQ_EXT) : sum_s[IDX_W-1:0];
            hit_s       = req_valid_in[cand_s] & ~grant_vld_s;
            grant_idx_s = hit_s ? cand_s : grant_idx_s;
            grant_vld_s = grant_vld_s | hit_s;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_op_s = grant_op_s |
                         (req_data_in[i*WIDTH +: WIDTH] & {WIDTH{grant_idx_s == IDX_W'(i)}});
        end
    end

    // Next-state and output decode for the single outstanding operation.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        op_d           = op_q;
        res_d          = res_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        req_ready_out  = '0;
        resp_valid_out = '0;
        resp_data_out  = '0;
        resp_err_out   = 1'b0;
        unit_a_out     = '0;
        unit_valid_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s && unit_ready_in && rst_in) begin
                    req_ready_out[grant_idx_s] = 1'b1;
                    op_d    = grant_op_s;
                    owner_d = grant_idx_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                unit_valid_out = 1'b1;
                unit_a_out     = op_q;
                if (unit_ready_in) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A result arriving in the final watchdog cycle still wins over the timeout.
                if (unit_valid_in) begin
                    res_d   = unit_res_in;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                resp_valid_out[owner_q] = 1'b1;
                resp_data_out  = res_q;
                resp_err_out   = err_q;
                rr_ptr_d       = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_inv_sqrt_arbiter.sv
// Randomised bench for fp_inv_sqrt_arbiter: a transaction-level model predicts every
// output each cycle, and a stub inverse-square-root unit (Q16.16) answers issues.
module tb_fp_inv_sqrt_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 64;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   resp_valid;
    logic [W-1:0]    resp_data;
    logic            resp_err;
    logic [W-1:0]    unit_a;
    logic            unit_vld_from_dut;
    logic            unit_ready;
    logic [W-1:0]    unit_res;
    logic            unit_vld_to_dut;

    fp_inv_sqrt_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .req_valid_in   (req_valid),
        .req_data_in    (req_data),
        .req_ready_out  (req_ready),
        .resp_valid_out (resp_valid),
        .resp_data_out  (resp_data),
        .resp_err_out   (resp_err),
        .unit_a_out     (unit_a),
        .unit_valid_out (unit_vld_from_dut),
        .unit_ready_in  (unit_ready),
        .unit_res_in    (unit_res),
        .unit_valid_in  (unit_vld_to_dut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Transaction-level model of the arbiter
    bit          m_pend, m_issued, m_resp, m_err;
    int          m_owner, m_ptr, m_waitn;
    logic [31:0] m_op, m_res;

    // Stub unit
    bit          stub_busy, stub_v, stub_mute, stub_mute_acc, late_pulse;
    int          stub_cnt, stub_lat;
    logic [31:0] stub_a, stub_r;

    // Per-cycle samples and per-operation records
    logic [3:0]  s_ready, s_rv;
    logic [31:0] s_a, s_rd;
    logic        s_uv, s_err;
    logic [3:0]  grant_vec, st_vec;
    logic [31:0] st_data;
    logic        st_err;
    int          grant_cyc, strobe_cyc, strobe_cnt;
    bit          strobe_seen;

    function automatic logic [31:0] inv_sqrt_fx(input logic [31:0] a);
        real x;
        real r;
        x = real'(a) / 65536.0;
        r = 65536.0 / $sqrt(x);
        return 32'($rtoi(r + 0.5));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input real want);
        real got;
        got = real'(act) / 65536.0;
        checks++;
        if (got - want > 1.0e-4 || want - got > 1.0e-4) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%f want=%f", name, cyc, got, want);
        end
    endtask

    task automatic model_clear();
        m_pend = 0; m_issued = 0; m_resp = 0; m_err = 0;
        m_owner = 0; m_ptr = 0; m_waitn = 0; m_op = '0; m_res = '0;
    endtask

    // One clock cycle: inputs are already set at the preceding negedge.
    task automatic step();
        int win, idx;
        logic [3:0]  e_ready, e_rv;
        logic [31:0] e_a, e_rd;
        logic        e_uv, e_err;
        unit_vld_to_dut = stub_v;
        unit_res        = stub_v ? stub_r : $urandom();
        if (late_pulse) begin
            unit_vld_to_dut = 1'b1;
            unit_res        = $urandom();
            late_pulse      = 0;
        end
        #1;
        win = -1;
        if (rst_n && !m_pend && !m_resp && unit_ready) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        e_ready = (win >= 0) ? (4'b0001 << win) : 4'b0000;
        e_uv    = m_pend && !m_issued;
        e_a     = e_uv ? m_op : 32'h0;
        e_rv    = m_resp ? (4'b0001 << m_owner) : 4'b0000;
        e_rd    = m_resp ? m_res : 32'h0;
        e_err   = m_resp && m_err;
        s_ready = req_ready; s_rv = resp_valid; s_a = unit_a; s_rd = resp_data;
        s_uv = unit_vld_from_dut; s_err = resp_err;
        chk("req_ready", 32'(s_ready), 32'(e_ready));
        chk("unit_valid", 32'(s_uv), 32'(e_uv));
        chk("unit_a", s_a, e_a);
        chk("resp_valid", 32'(s_rv), 32'(e_rv));
        chk("resp_data", s_rd, e_rd);
        chk("resp_err", 32'(s_err), 32'(e_err));
        if (s_ready != 4'b0000 && grant_vec == 4'b0000) begin
            grant_vec = s_ready; grant_cyc = cyc;
        end
        if (s_rv != 4'b0000) begin
            strobe_seen = 1; strobe_cyc = cyc; strobe_cnt++;
            st_vec = s_rv; st_data = s_rd; st_err = s_err;
        end
        // model advances across the coming edge
        if (!rst_n) begin
            model_clear();
        end else if (m_resp) begin
            m_resp = 0;
            m_ptr  = (m_owner + 1) % NR;
        end else if (win >= 0) begin
            m_pend = 1; m_issued = 0; m_owner = win; m_op = req_data[win*W +: W];
        end else if (m_pend && !m_issued) begin
            if (unit_ready) begin m_issued = 1; m_waitn = 0; end
        end else if (m_pend) begin
            if (unit_vld_to_dut) begin
                m_resp = 1; m_res = unit_res; m_err = 0; m_pend = 0;
            end else begin
                m_waitn++;
                if (m_waitn == TO) begin m_resp = 1; m_res = '0; m_err = 1; m_pend = 0; end
            end
        end
        stub_v = 0;
        if (stub_busy) begin
            if (stub_cnt <= 1) begin
                stub_busy = 0; stub_v = !stub_mute_acc; stub_r = inv_sqrt_fx(stub_a);
            end else begin
                stub_cnt--;
            end
        end else if (s_uv && unit_ready) begin
            stub_busy = 1; stub_cnt = stub_lat; stub_a = s_a; stub_mute_acc = stub_mute;
        end
        @(posedge clk);
        #1;
        if (win >= 0) req_valid[win] = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_op(input int budget);
        int n;
        n = 0;
        strobe_seen = 0; grant_vec = '0; grant_cyc = -1;
        while (!strobe_seen && n < budget) begin
            step();
            n++;
        end
        chk("op_budget", 32'(strobe_seen), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c0;
        logic [3:0] rr_grant [4];
        logic [31:0] rr_res [4];
        real rr_want [4];
        rr_want[0] = 1.0; rr_want[1] = 0.5; rr_want[2] = 1.4142; rr_want[3] = 0.25;
        rst_n = 1'b0; req_valid = '0; req_data = '0; unit_ready = 1'b1;
        unit_res = '0; unit_vld_to_dut = 1'b0;
        stub_busy = 0; stub_v = 0; stub_mute = 0; stub_mute_acc = 0; late_pulse = 0;
        stub_cnt = 0; stub_lat = 5; stub_a = '0; stub_r = '0;
        grant_vec = '0; st_vec = '0; st_data = '0; st_err = 1'b0;
        strobe_cnt = 0; strobe_seen = 0; grant_cyc = -1; strobe_cyc = -1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        step();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_uvalid", 32'(s_uv), 32'd0);
        chk("rst_resp", 32'(s_rv), 32'd0);
        rst_n = 1'b1;

        // single request, 5-cycle unit
        stub_lat = 5;
        req_data[0 +: 32] = 32'h0000_4000;
        req_valid = 4'b0001;
        run_op(40);
        chk("single_grant", 32'(grant_vec), 32'h1);
        chk("single_strobe", 32'(st_vec), 32'h1);
        chk_near("single_data", st_data, 2.0);
        chk("single_err", 32'(st_err), 32'd0);
        chk("single_latency", 32'(strobe_cyc - grant_cyc), 32'd8);

        // round robin 0,1,2,3 then wrap to 0
        rst_n = 1'b0; step(); rst_n = 1'b1;
        stub_lat = 2;
        req_data = {32'h0010_0000, 32'h0000_8000, 32'h0004_0000, 32'h0001_0000};
        req_valid = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            run_op(40);
            rr_grant[j] = grant_vec;
            rr_res[j] = st_data;
        end
        for (int j = 0; j < 4; j++) begin
            chk("rr_grant", 32'(rr_grant[j]), 32'(4'b0001 << j));
            chk_near("rr_result", rr_res[j], rr_want[j]);
        end
        req_valid = 4'b0011;
        run_op(40);
        req_valid = 4'b0000;
        chk("rr_wrap", 32'(grant_vec), 32'h1);

        // unit busy: no grant until unit_ready rises
        unit_ready = 1'b0;
        req_data[2*W +: W] = 32'h0000_4000;
        req_valid = 4'b0100;
        repeat (10) begin
            step();
            chk("busy_hold", 32'(s_ready), 32'd0);
        end
        unit_ready = 1'b1;
        c0 = cyc;
        run_op(40);
        chk("busy_grant", 32'(grant_vec), 32'h4);
        chk("busy_grant_cyc", 32'(grant_cyc), 32'(c0));

        // timeout, then a late pulse must be ignored
        stub_mute = 1;
        req_data[3*W +: W] = 32'h0001_0000;
        req_valid = 4'b1000;
        run_op(TO + 20);
        stub_mute = 0;
        chk("to_strobe", 32'(st_vec), 32'h8);
        chk("to_err", 32'(st_err), 32'd1);
        chk("to_data", st_data, 32'h0);
        chk("to_latency", 32'(strobe_cyc - grant_cyc), 32'(TO + 2));
        strobe_cnt = 0;
        late_pulse = 1;
        repeat (10) step();
        chk("late_pulse_ignored", 32'(strobe_cnt), 32'd0);

        // reset in WAIT: no response, pointer returns to 0
        req_data[1*W +: W] = 32'h0004_0000;
        req_valid = 4'b0010;
        run_op(40);
        stub_lat = 20;
        req_valid = 4'b0100;
        repeat (6) step();
        rst_n = 1'b0;
        step();
        chk("rstw_ready", 32'(s_ready), 32'd0);
        chk("rstw_uvalid", 32'(s_uv), 32'd0);
        chk("rstw_resp", 32'(s_rv), 32'd0);
        chk("rstw_data", s_rd, 32'h0);
        rst_n = 1'b1;
        strobe_cnt = 0;
        repeat (25) step();
        chk("rstw_no_resp", 32'(strobe_cnt), 32'd0);
        stub_lat = 2;
        req_data[0 +: 32] = 32'h0001_0000;
        req_data[3*W +: W] = 32'h0001_0000;
        req_valid = 4'b1001;
        run_op(40);
        req_valid = 4'b0000;
        chk("rstw_next_grant", 32'(grant_vec), 32'h1);

        // randomised traffic
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*W +: W] = $urandom_range(1, 32'h00FF_FFFF);
                end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            unit_ready = ($urandom_range(0, 4) != 0);
            stub_lat   = $urandom_range(1, 6);
            stub_mute  = ($urandom_range(0, 39) == 0);
            late_pulse = ($urandom_range(0, 29) == 0);
            rst_n      = ($urandom_range(0, 199) != 0);
            step();
        end
        req_valid = '0; unit_ready = 1'b1; stub_mute = 0; rst_n = 1'b1;
        repeat (TO + 20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_inv_sqrt_arbiter.md
# fp_inv_sqrt_arbiter

Round-robin arbiter that shares a single `fp_inv_sqrt_folded` unit between `NUM_REQ` requesters, e.g. the ray marcher's normal-normalisation and direction-normalisation stages. It accepts one request at a time over a valid/ready handshake and issues it to the unit. It waits for the result, with a watchdog, and returns it to the owning requester as a one-cycle tagged response. Only one operation is outstanding at any time, matching the folded unit's non-pipelined behaviour.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2).
- `WIDTH`, 32, width of the `fp` fixed-point type.
- `TIMEOUT`, 64, maximum cycles spent in WAIT before an error response.

Ports (one clock; reset is synchronous and active-low):
- `clk_in`  in  1  system clock; all state updates on rising edge.
- `rst_in`  in  1  synchronous, active-low reset (0 = reset).
- `req_valid_in`  in  NUM_REQ  per-requester request valid.
- `req_data_in`  in  NUM_REQ*WIDTH  operand; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready_out`  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high at a clock edge.
- `resp_valid_out`  out  NUM_REQ  one-hot, one-cycle response strobe.
- `resp_data_out`  out  WIDTH  shared result bus, valid when any `resp_valid_out` bit is high.
- `resp_err_out`  out  1  high with the strobe when the response is a timeout.
- `unit_a_out`  out  WIDTH  operand to the unit (`a_in`).
- `unit_valid_out`  out  1  to the unit's `valid_in`.
- `unit_ready_in`  in  1  from the unit's `ready_out`.
- `unit_res_in`  in  WIDTH  from the unit's `res_out`.
- `unit_valid_in`  in  1  from the unit's `valid_out`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_in` is high and `unit_ready_in`=1, combinationally raise `req_ready_out[g]` for winner g.
  - g is the first requester with valid set, searching from `rr_ptr` upward, mod NUM_REQ.
  - At the edge: latch the operand into `op_q`, set `owner_q`=g, and go to ISSUE.
  - If `unit_ready_in`=0, all `req_ready_out` are 0 and the FSM stays in IDLE.
- **ISSUE**
  - Drive `unit_valid_out`=1 and `unit_a_out`=`op_q`.
  - Go to WAIT on the edge where `unit_ready_in`=1; otherwise hold.
  - Clear the watchdog counter on entry to WAIT.
- **WAIT**
  - `unit_valid_out`=0.
  - On `unit_valid_in`=1: latch `unit_res_in` into `res_q`, set `err_q`=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without a result: set `res_q`=0, `err_q`=1, go to RESP.
- **RESP**
  - Drive `resp_valid_out[owner_q]`=1, `resp_data_out`=`res_q`, `resp_err_out`=`err_q` for exactly one cycle.
  - Set `rr_ptr` = (owner_q+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0, then return to IDLE.
- `unit_valid_in` pulses received outside WAIT are ignored, including late results after a timeout.
- Requesters have no response back-pressure; they must sample the strobe.
- Data passes through unmodified; the arbiter performs no arithmetic on operands.

## Timing
- Reset (`rst_in`=0 at an edge):
  - FSM goes to IDLE; `rr_ptr`, `owner_q`, `op_q`, `res_q`, `err_q` and the counter are cleared to 0.
  - All outputs read 0 while the FSM is in IDLE: `req_ready_out` is forced to 0 while `rst_in`=0.
  - Reset mid-operation discards the in-flight operation; no response is produced.
- Grant at edge E0 gives: `unit_valid_out` high in cycle E0+1; if `unit_ready_in`=1 there, WAIT starts at E0+2.
- A unit result in cycle Ck gives the response strobe in cycle Ck+1.
- Total latency is unit latency + 3 cycles from grant edge to response strobe.
- Minimum issue interval is unit latency + 4 cycles; the next grant can occur in the cycle after the RESP cycle.
- Simultaneous requests resolve strictly round-robin; a requester that holds valid waits at most NUM_REQ-1 operations.
- A request that deasserts valid before being granted is dropped without side effects.

## Test plan
- **Single request.** Requester 0 sends `fp_from_real(0.25)`; the stub unit has 5-cycle latency.
  - Expect `req_ready_out`=4'b0001 at the grant edge and the strobe on `resp_valid_out`=4'b0001.
  - Expect `resp_data_out` ≈ 2.0 within 1e-4, `resp_err_out`=0, and the strobe exactly 8 cycles after the grant edge.
- **Round-robin with wrap.** All four requesters hold valid with operands 1.0, 4.0, 0.5, 16.0.
  - Grants in order 0,1,2,3; results 1.0, 0.5, 1.4142, 0.25.
  - Requester 0 re-asserts afterwards and is granted next, proving `rr_ptr` wraps to 0.
- **Unit busy.** Hold `unit_ready_in`=0 for 10 cycles while requester 2 is valid.
  - `req_ready_out` stays 0; the grant arrives the cycle `unit_ready_in` rises.
- **Timeout.** The stub never asserts `unit_valid_in`.
  - After TIMEOUT cycles in WAIT: `resp_valid_out[owner]`=1, `resp_err_out`=1, `resp_data_out`=0.
  - A late stub pulse afterwards produces no strobe.
- **Reset mid-WAIT.** Drive `rst_in`=0 for one cycle during WAIT.
  - All outputs are 0, no response is issued, and the next grant goes to requester 0.
